pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter CPU_WIDTH, default 32, SHALL set the address, data and instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded at reset.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 ena  in  1  fetch enable; low SHALL block new requests only.
REQ-006 redirect  in  1  branch/jump taken, one-cycle pulse from execute.
REQ-007 redirect_pc  in  CPU_WIDTH  target PC, valid while redirect=1.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  CPU_WIDTH  request address.
REQ-010 imem_gnt  in  1  request accepted this cycle.
REQ-011 imem_rvalid  in  1  read data valid; SHALL arrive 1+ cycles after gnt.
REQ-012 imem_rdata  in  CPU_WIDTH  instruction word.
REQ-013 if_valid  out  1  instruction available to decode.
REQ-014 if_ready  in  1  decode accepts the instruction.
REQ-015 if_pc  out  CPU_WIDTH  PC of the presented instruction.
REQ-016 if_instr  out  CPU_WIDTH  presented instruction.

Function
REQ-017 The PC register SHALL advance by CPU_WIDTH'h4 on each granted request (imem_req && imem_gnt), with modulo-2^CPU_WIDTH wrap (32'hFFFF_FFFC -> 32'h0).
REQ-018 On redirect, the next PC SHALL be redirect_pc; redirect SHALL take priority over increment in the same cycle.
REQ-019 The FSM SHALL have states IDLE, REQ and WAIT, with at most one outstanding request.
REQ-020 IDLE -> REQ SHALL occur when ena=1, redirect=0 and FIFO count < 2.
REQ-021 REQ -> WAIT SHALL occur on imem_gnt=1.
REQ-022 WAIT -> IDLE SHALL occur on imem_rvalid=1.
REQ-023 imem_req SHALL be 1 exactly in REQ, with imem_addr = PC.
REQ-024 Once asserted, imem_req/imem_addr SHALL be held stable until grant; ena falling SHALL NOT withdraw a pending request.
REQ-025 Redirect in REQ without gnt SHALL withdraw the request (-> IDLE).
REQ-026 Redirect in REQ with gnt, or in WAIT, SHALL set a drop flag; the next rvalid SHALL then be discarded and the flag cleared.
REQ-027 A 2-entry FIFO of {pc, instr} SHALL push on rvalid when drop=0, pushing the PC latched at grant.
REQ-028 if_valid SHALL be 1 when the FIFO is non-empty and redirect=0; if_pc/if_instr SHALL come from the head entry.
REQ-029 The FIFO SHALL pop on if_valid && if_ready; simultaneous push and pop SHALL leave the count unchanged.
REQ-030 The FIFO SHALL never overflow; REQ-020 guarantees a free slot for every outstanding response.
REQ-031 Redirect SHALL flush the FIFO (count 0 next cycle); any pop or push in that cycle SHALL be ignored.
REQ-032 Redirect coinciding with rvalid SHALL discard that response.
REQ-033 Latency SHALL be 1 cycle: rvalid at cycle N gives if_valid=1 at N+1.
REQ-034 With ena=0 and an empty FIFO, the block SHALL go idle after any outstanding response returns.

Reset
REQ-035 While rst_n=0: PC=RESET_PC, state=IDLE, drop=0, FIFO empty, imem_req=0, if_valid=0, imem_addr=RESET_PC, if_pc=0, if_instr=0.
REQ-036 Reset asserted mid-transaction SHALL abandon it immediately; a later rvalid with no request outstanding SHALL be ignored.
REQ-037 The first imem_req SHALL assert in the cycle after rst_n rises, if ena=1.

Verification
REQ-038 Reset release, ena=1, gnt same cycle, rvalid 1 cycle later, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, with instructions matching memory.
REQ-039 if_ready=0 for 10 cycles -> FIFO fills to 2, imem_req stays 0, no data lost; resume -> PCs are in order.
REQ-040 In WAIT at PC 0x10, redirect to 0x200 -> stale response dropped, next request at 0x200, if_pc=0x200.
REQ-041 Redirect while in REQ with gnt=0 -> request withdrawn; next imem_addr=redirect_pc; no stale push.
REQ-042 redirect_pc=0xFFFF_FFFC -> fetch at 0xFFFF_FFFC, then at 0x0000_0000.
REQ-043 rst_n pulsed low during WAIT -> outputs at reset values; late rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch front end: PC register, single-outstanding imem request FSM
// and a 2-entry {pc, instr} skid FIFO toward decode.
module pc_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 redirect,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [CPU_WIDTH-1:0] if_pc,
    output logic [CPU_WIDTH-1:0] if_instr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state;
    logic [CPU_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0] req_pc;
    logic                 drop;

    logic [CPU_WIDTH-1:0] fifo_pc    [2];
    logic [CPU_WIDTH-1:0] fifo_instr [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           count;

    logic grant;
    logic push;
    logic pop;

    assign grant     = imem_req && imem_gnt;
    // A response is only meaningful while a request is outstanding
    assign push      = (state == WAIT) && imem_rvalid && !drop && !redirect;
    assign pop       = if_valid && if_ready;
    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0) && !redirect;
    assign if_pc     = fifo_pc[rd_ptr];
    assign if_instr  = fifo_instr[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (grant) begin
            pc <= pc + CPU_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            drop     <= 1'b0;
            req_pc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // count < 2 reserves a FIFO slot for the response
                    if (ena && !redirect && (count < 2'd2)) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        req_pc   <= pc;
                        drop     <= redirect;
                    end else if (redirect) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (redirect) begin
                        drop  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= req_pc;
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a one-cycle-latency memory responder plus a
// decode sink; all stimulus and sampling happens on the falling edge.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int n_tests = 0;
    int n_fail  = 0;

    logic        gnt_en, rv_en, pend;
    logic [31:0] pend_addr;
    logic [31:0] got_pc[$], got_in[$], gnt_q[$];

    pc_fetch #(.CPU_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: record handshakes about to happen, then update the responder.
    task automatic cyc();
        logic        g;
        logic [31:0] ga;
        imem_gnt = gnt_en;
        #1;
        if (if_valid && if_ready) begin
            got_pc.push_back(if_pc);
            got_in.push_back(if_instr);
        end
        g  = rst_n && imem_req && imem_gnt;
        ga = imem_addr;
        @(posedge clk);
        @(negedge clk);
        if (g) begin
            pend      = 1'b1;
            pend_addr = ga;
            gnt_q.push_back(ga);
        end
        imem_rvalid = 1'b0;
        if (pend && rv_en) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem(pend_addr);
            pend        = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse(input logic [31:0] p);
        redirect    = 1'b1;
        redirect_pc = p;
        cyc();
        redirect    = 1'b0;
    endtask

    task automatic park(input logic [31:0] p);
        ena = 1'b0; rv_en = 1'b1; gnt_en = 1'b1; if_ready = 1'b1;
        run(10);
        pulse(p);
        got_pc.delete(); got_in.delete(); gnt_q.delete();
    endtask

    task automatic wait_req(input int max);
        for (int i = 0; i < max && !imem_req; i++) cyc();
        check("wait_req", {31'b0, imem_req}, 32'h1);
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b1;
        gnt_en = 1'b1; rv_en = 1'b1; pend = 1'b0; pend_addr = '0;
        @(negedge clk);
        run(3);

        // reset values
        check("rst_req",   {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);

        // first request the cycle after release, 1-cycle response latency
        rst_n = 1'b1;
        cyc();
        check("first_req",  {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        cyc();
        check("lat_n",      {31'b0, if_valid}, 32'h0);
        cyc();
        check("lat_n1",     {31'b0, if_valid}, 32'h1);
        check("lat_pc",     if_pc, 32'h0);
        run(10);
        check("seq_pc0", qat(got_pc, 0), 32'h0);
        check("seq_pc1", qat(got_pc, 1), 32'h4);
        check("seq_pc2", qat(got_pc, 2), 32'h8);
        check("seq_in0", qat(got_in, 0), mem(32'h0));
        check("seq_in2", qat(got_in, 2), mem(32'h8));

        // backpressure: FIFO fills to 2, requests stop, nothing lost
        park(32'h100);
        check("idle_ena0", {31'b0, imem_req}, 32'h0);
        if_ready = 1'b0; ena = 1'b1;
        run(14);
        check("bp_req",    {31'b0, imem_req}, 32'h0);
        check("bp_valid",  {31'b0, if_valid}, 32'h1);
        check("bp_head",   if_pc, 32'h100);
        check("bp_nopop",  got_pc.size(), 32'h0);
        check("bp_fetch",  gnt_q.size(), 32'h2);
        if_ready = 1'b1;
        run(20);
        check("bp_pc0", qat(got_pc, 0), 32'h100);
        check("bp_pc1", qat(got_pc, 1), 32'h104);
        check("bp_pc2", qat(got_pc, 2), 32'h108);
        check("bp_pc3", qat(got_pc, 3), 32'h10C);
        check("bp_in1", qat(got_in, 1), mem(32'h104));

        // redirect while WAIT at 0x10: stale response dropped
        park(32'h10);
        rv_en = 1'b0; ena = 1'b1;
        run(4);
        check("w_gnt", qat(gnt_q, 0), 32'h10);
        gnt_q.delete();
        pulse(32'h200);
        rv_en = 1'b1;
        run(15);
        check("w_addr", qat(gnt_q, 0), 32'h200);
        check("w_pc",   qat(got_pc, 0), 32'h200);
        check("w_in",   qat(got_in, 0), mem(32'h200));

        // redirect in REQ without grant: request withdrawn
        park(32'h80);
        gnt_en = 1'b0; ena = 1'b1;
        cyc();
        check("r_req",  {31'b0, imem_req}, 32'h1);
        check("r_addr", imem_addr, 32'h80);
        ena = 1'b0;
        run(2);
        check("r_hold_req",  {31'b0, imem_req}, 32'h1);
        check("r_hold_addr", imem_addr, 32'h80);
        ena = 1'b1;
        pulse(32'h300);
        check("r_withdrawn", {31'b0, imem_req}, 32'h0);
        wait_req(5);
        check("r_new_addr", imem_addr, 32'h300);
        gnt_en = 1'b1;
        run(10);
        check("r_gnt0", qat(gnt_q, 0), 32'h300);
        check("r_pc0",  qat(got_pc, 0), 32'h300);

        // wrap at the top of the address space
        park(32'hFFFF_FFFC);
        ena = 1'b1;
        run(12);
        check("wrap_g0",  qat(gnt_q, 0), 32'hFFFF_FFFC);
        check("wrap_g1",  qat(gnt_q, 1), 32'h0);
        check("wrap_pc0", qat(got_pc, 0), 32'hFFFF_FFFC);
        check("wrap_pc1", qat(got_pc, 1), 32'h0);

        // reset during WAIT; late response must be ignored
        park(32'h40);
        rv_en = 1'b0; ena = 1'b1;
        run(4);
        check("m_gnt", qat(gnt_q, 0), 32'h40);
        rst_n = 1'b0;
        #1;
        check("m_req",   {31'b0, imem_req}, 32'h0);
        check("m_addr",  imem_addr, 32'h0);
        check("m_valid", {31'b0, if_valid}, 32'h0);
        check("m_if_pc", if_pc, 32'h0);
        ena = 1'b0;
        run(2);
        rst_n = 1'b1;
        got_pc.delete(); got_in.delete(); gnt_q.delete();
        rv_en = 1'b1;
        run(3);
        check("m_late_valid", {31'b0, if_valid}, 32'h0);
        check("m_late_req",   {31'b0, imem_req}, 32'h0);
        ena = 1'b1;
        run(10);
        check("m_restart_g", qat(gnt_q, 0), 32'h0);
        check("m_restart_p", qat(got_pc, 0), 32'h0);
        check("m_restart_n", got_pc.size() > 0 ? 32'h1 : 32'h0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
